// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage of the 5-stage RV32I pipeline. Sole driver of
//            the register file write port. Non-load results are written one
//            cycle after acceptance; loads wait for the data-memory response,
//            then the selected byte/halfword/word is aligned and extended.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            in_valid / in_ready    - handshake from the MEM stage
//            in_reg_write, in_rd,
//            in_is_load, in_funct3,
//            in_addr_lo,
//            in_alu_result          - retiring instruction fields
//            dmem_rvalid, dmem_rdata- data-memory read response
//            write_en/addr/value    - registered register file write port
//            load_pending           - high while a load is outstanding
//            load_timeout           - sticky load-timeout error flag
//            instret                - retired-instruction counter
// Options  : WB_INSTRET_EN - when defined, instret counts retire events;
//            otherwise instret is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int LOAD_TIMEOUT = 255,  // 0 = never time out
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_value,
  output logic        load_pending,
  output logic        load_timeout,
  output logic [63:0] instret
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [CNT_W:0] c_limit = (CNT_W+1)'(LOAD_TIMEOUT);

  state_t           r_state;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W:0]   w_cnt_next;
  logic             w_expire;
  logic [31:0]      w_shifted;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_value;

  assign in_ready     = (r_state == S_IDLE);
  assign load_pending = (r_state == S_WAIT_LOAD);

  // One extra bit so the comparison never wraps before reaching the limit.
  assign w_cnt_next = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_expire   = (LOAD_TIMEOUT != 0) && (w_cnt_next == c_limit);

  // Byte select by shifting the word down by addr_lo bytes; halfword select
  // only looks at addr_lo[1], so a misaligned LH silently rounds down.
  assign w_shifted = dmem_rdata >> {r_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load_value = dmem_rdata;  // LW and the unused encodings
    case (r_funct3)
      3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_value = {24'd0, w_byte};
      3'b101:  w_load_value = {16'd0, w_half};
      default: w_load_value = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      write_en     <= 1'b0;
      write_addr   <= 5'd0;
      write_value  <= 32'd0;
      load_timeout <= 1'b0;
      r_cnt        <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
    end else begin
      write_en <= 1'b0;  // strobe is a single-cycle pulse
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_is_load) begin
              r_reg_write <= in_reg_write;
              r_rd        <= in_rd;
              r_funct3    <= in_funct3;
              r_addr_lo   <= in_addr_lo;
              r_cnt       <= '0;
              r_state     <= S_WAIT_LOAD;
            end else begin
              write_en    <= in_reg_write && (in_rd != 5'd0);
              write_addr  <= in_rd;
              write_value <= in_alu_result;
            end
          end
        end
        S_WAIT_LOAD: begin
          // A response arriving on the expiry cycle still completes the load.
          if (dmem_rvalid) begin
            write_en    <= r_reg_write && (r_rd != 5'd0);
            write_addr  <= r_rd;
            write_value <= w_load_value;
            r_state     <= S_IDLE;
          end else if (w_expire) begin
            load_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next[CNT_W-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;
  logic        w_retire;

  // Timed-out loads leave without dmem_rvalid, so they never count.
  assign w_retire = ((r_state == S_IDLE) && in_valid && !in_is_load) ||
                    ((r_state == S_WAIT_LOAD) && dmem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= 64'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`else
  assign instret = 64'd0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I pipeline; sole driver of the register file write port (write_en/write_addr/write_value).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- For loads, waits a variable number of cycles for the data-memory response, then aligns and sign/zero-extends the data.
- Issues a registered one-cycle write pulse and a load-pending flag for the hazard unit.

Parameters:
LOAD_TIMEOUT, 255, max cycles waiting for dmem_rvalid before abandoning a load; 0 = never time out
CNT_W, 8, width of the timeout counter; must hold LOAD_TIMEOUT

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept; high exactly when state is IDLE
in_reg_write  input  1  instruction writes rd
in_rd  input  5  destination register
in_is_load  input  1  instruction is a load
in_funct3  input  3  load width/sign code
in_addr_lo  input  2  low bits of load byte address
in_alu_result  input  32  result for non-load instructions
dmem_rvalid  input  1  data-memory read data valid
dmem_rdata  input  32  data-memory read word, little-endian
write_en  output  1  register file write strobe, one-cycle pulse
write_addr  output  5  register file write address
write_value  output  32  register file write data
load_pending  output  1  high while in WAIT_LOAD, for stall/forward logic
load_timeout  output  1  sticky error flag, set on load timeout
instret  output  64  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State IDLE; write_en=0, write_addr=0, write_value=0.
  - load_pending=0, load_timeout=0, timeout counter=0, instret=0.
  - Reset overrides every other event in that cycle, including mid-WAIT_LOAD; the pending load is discarded.
- States: IDLE, WAIT_LOAD.
- IDLE, in_valid=1 with in_is_load=0:
  - Next cycle: write_en = in_reg_write && in_rd!=0; write_addr=in_rd; write_value=in_alu_result.
  - Latency 1; stays in IDLE, so back-to-back acceptance is possible every cycle.
- IDLE, in_valid=1 with in_is_load=1:
  - Capture in_rd, in_reg_write, in_funct3, in_addr_lo; clear the timeout counter; go to WAIT_LOAD.
  - write_en=0 next cycle.
- IDLE, in_valid=0: write_en=0; write_addr and write_value hold their last values.
- WAIT_LOAD:
  - in_ready=0 and load_pending=1.
  - On dmem_rvalid=1: align and extend the data; next cycle write_en = captured reg_write && rd!=0 with the aligned value; return to IDLE (in_ready=1 that cycle).
  - Data arriving in the same cycle as entry is not possible; the earliest response is the cycle after acceptance.
- Alignment, where b = dmem_rdata byte at in_addr_lo and h = dmem_rdata halfword at in_addr_lo[1]:
  - 000 LB: sign-extend b.
  - 001 LH: sign-extend h; in_addr_lo[0] ignored.
  - 010 LW: full word.
  - 100 LBU: zero-extend b.
  - 101 LHU: zero-extend h.
  - 011, 110, 111: treated as LW.
- Timeout (LOAD_TIMEOUT>0):
  - Counter increments each WAIT_LOAD cycle without dmem_rvalid.
  - When the counter reaches LOAD_TIMEOUT: set load_timeout (sticky until reset), return to IDLE, no write.
  - dmem_rvalid in the same cycle the count reaches LOAD_TIMEOUT wins: the normal write occurs and the flag stays clear.
- dmem_rvalid while IDLE is ignored (late or stray response).
- write_en is never high for two cycles from a single instruction.
- x0 is never written; write_en=0 whenever rd=0.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: instret is a 64-bit counter, +1 on every retire event, wrapping at 2^64-1 → 0.
  - A retire event is a non-load acceptance, or a load completion via dmem_rvalid.
  - rd=0 and in_reg_write=0 instructions count; timed-out loads do not.
- Undefined: instret tied to 0 and no counter logic.

Test Plan:
- Reset then ADD rd=5, alu=0x0000_1234 on in_valid → one cycle later write_en=1, write_addr=5, write_value=0x1234; following cycle write_en=0.
- LB rd=10, addr_lo=3, rvalid after 4 cycles with rdata=0x80FF_FFFF → in_ready=0 and load_pending=1 for 4 cycles; then write_value=0xFFFF_FF80; LBU with the same data → 0x0000_0080.
- LH addr_lo=2, rdata=0x8001_7FFF → 0xFFFF_8001; LHU → 0x0000_8001; LW → 0x8001_7FFF.
- Non-load with rd=0, alu=0xDEAD_BEEF → write_en stays 0; with WB_INSTRET_EN, instret increments by 1.
- LOAD_TIMEOUT=3, load with no rvalid → WAIT_LOAD for 3 cycles, then IDLE with load_timeout=1 and no write; a later stray dmem_rvalid in IDLE is ignored.
- Reset asserted during WAIT_LOAD, then rvalid=1 next cycle → no write, state IDLE, all outputs at reset values.
